// File: rtl/alu_sequencer_if.sv
// Command, ALU and writeback bundle for the ALU issue sequencer.
// The slave side is the sequencer. The master side is everything around it:
// the decode stage that issues commands, the combinational ALU that returns
// alu_out, and the writeback consumer.
interface alu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int IMM_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode;
    logic [RD_W-1:0]   cmd_rd;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [IMM_W-1:0]  cmd_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_out;

    logic              wb_valid;
    logic              wb_ready;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic              wb_err;
    logic              branch_taken;
    logic              flag_z;

    modport master (
        output cmd_valid, cmd_opcode, cmd_rd, cmd_a, cmd_b, cmd_imm,
        output alu_out, wb_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  wb_valid, wb_rd, wb_data, wb_we, wb_err, branch_taken, flag_z
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_rd, cmd_a, cmd_b, cmd_imm,
        input  alu_out, wb_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output wb_valid, wb_rd, wb_data, wb_we, wb_err, branch_taken, flag_z
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 16-bit ALU.
// A command is accepted in IDLE, its opcode is mapped onto the ALU inputs,
// and the ALU result is captured one cycle later (EXEC). The result is then
// held as a writeback record until the consumer takes it (WB).
module alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int IMM_W  = 6
) (
    input logic         clk,
    input logic         rst_n,
    alu_sequencer_if.slave bus
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_PASS = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t state_reg, state_next;
    logic   ready;
    logic   accept;
    logic   capture;
    logic   release_wb;

    // Decoded view of the command currently on the input port.
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] dec_a, dec_b;
    logic [2:0]        dec_op;
    logic              dec_we, dec_err, dec_beq;

    // Per-command state, held from accept until the EXEC capture.
    logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
    logic [2:0]        alu_op_reg;
    logic [RD_W-1:0]   rd_reg;
    logic              we_reg, err_reg, beq_reg;

    // Writeback record.
    logic              wb_valid_reg;
    logic [RD_W-1:0]   wb_rd_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic              wb_we_reg, wb_err_reg, branch_taken_reg, flag_z_reg;

    // The zero test is made here rather than relying on an ALU zero output.
    logic              result_zero;

    assign imm_sext    = {{(DATA_W-IMM_W){bus.cmd_imm[IMM_W-1]}}, bus.cmd_imm};
    assign result_zero = (bus.alu_out == '0);

    // Map the opcode onto the ALU operands, the ALU op and the record class.
    always_comb begin
        dec_a   = bus.cmd_a;
        dec_b   = bus.cmd_b;
        dec_op  = bus.cmd_opcode[2:0];
        dec_we  = 1'b1;
        dec_err = 1'b0;
        dec_beq = 1'b0;
        case (bus.cmd_opcode)
            4'd8: begin
                dec_b  = imm_sext;
                dec_op = OP_ADD;
            end
            4'd9: begin
                dec_b  = imm_sext;
                dec_op = OP_SUB;
            end
            4'd10: begin
                dec_a  = imm_sext;
                dec_b  = '0;
                dec_op = OP_PASS;
            end
            4'd11: begin
                dec_op  = OP_SUB;
                dec_we  = 1'b0;
                dec_beq = 1'b1;
            end
            4'd12: begin
                dec_op = OP_SUB;
                dec_we = 1'b0;
            end
            4'd13, 4'd14, 4'd15: begin
                // Illegal: park the ALU on a harmless pass of A. The record
                // still completes so the issuer always sees a response.
                dec_b   = '0;
                dec_op  = OP_PASS;
                dec_we  = 1'b0;
                dec_err = 1'b1;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next state and the strobes that step the datapath.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        release_wb = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = WB;
            end
            WB: begin
                if (bus.wb_ready) begin
                    release_wb = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the decoded command at accept; the ALU inputs stay put through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= '0;
            rd_reg     <= '0;
            we_reg     <= 1'b0;
            err_reg    <= 1'b0;
            beq_reg    <= 1'b0;
        end else if (accept) begin
            alu_a_reg  <= dec_a;
            alu_b_reg  <= dec_b;
            alu_op_reg <= dec_op;
            rd_reg     <= bus.cmd_rd;
            we_reg     <= dec_we;
            err_reg    <= dec_err;
            beq_reg    <= dec_beq;
        end
    end

    // Capture the ALU result into the writeback record and hold it until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg     <= 1'b0;
            wb_rd_reg        <= '0;
            wb_data_reg      <= '0;
            wb_we_reg        <= 1'b0;
            wb_err_reg       <= 1'b0;
            branch_taken_reg <= 1'b0;
            flag_z_reg       <= 1'b0;
        end else if (capture) begin
            wb_valid_reg     <= 1'b1;
            wb_rd_reg        <= rd_reg;
            wb_data_reg      <= bus.alu_out;
            wb_we_reg        <= we_reg;
            wb_err_reg       <= err_reg;
            branch_taken_reg <= beq_reg && result_zero;
            if (!err_reg) flag_z_reg <= result_zero;
        end else if (release_wb) begin
            wb_valid_reg <= 1'b0;
        end
    end

    assign bus.cmd_ready    = ready;
    assign bus.alu_a        = alu_a_reg;
    assign bus.alu_b        = alu_b_reg;
    assign bus.alu_op       = alu_op_reg;
    assign bus.wb_valid     = wb_valid_reg;
    assign bus.wb_rd        = wb_rd_reg;
    assign bus.wb_data      = wb_data_reg;
    assign bus.wb_we        = wb_we_reg;
    assign bus.wb_err       = wb_err_reg;
    assign bus.branch_taken = branch_taken_reg;
    assign bus.flag_z       = flag_z_reg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed cases followed by random commands.
// Each command is checked against an opcode-level reference model.
// The bench also plays the combinational ALU.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic model_z;

    alu_sequencer_if #(.DATA_W(16), .RD_W(3), .IMM_W(6)) bus ();

    alu_sequencer #(.DATA_W(16), .RD_W(3), .IMM_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU as seen by the sequencer.
    always_comb begin
        bus.alu_out = '0;
        case (bus.alu_op)
            3'd0: bus.alu_out = bus.alu_a + bus.alu_b;
            3'd1: bus.alu_out = bus.alu_a - bus.alu_b;
            3'd2: bus.alu_out = bus.alu_a >> bus.alu_b;
            3'd3: bus.alu_out = bus.alu_a << bus.alu_b;
            3'd4: bus.alu_out = ~(bus.alu_a & bus.alu_b);
            3'd5: bus.alu_out = bus.alu_a | bus.alu_b;
            3'd6: bus.alu_out = bus.alu_a;
            3'd7: bus.alu_out = 16'($signed(bus.alu_a) >>> bus.alu_b);
            default: bus.alu_out = '0;
        endcase
    end

    // Result an instruction should write back, straight from its meaning.
    function automatic logic [15:0] ref_data(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [5:0] imm);
        logic [15:0] sx;
        sx = {{10{imm[5]}}, imm};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a >> b;
            4'd3:  return a << b;
            4'd4:  return ~(a & b);
            4'd5:  return a | b;
            4'd6:  return a;
            4'd7:  return 16'($signed(a) >>> b);
            4'd8:  return a + sx;
            4'd9:  return a - sx;
            4'd10: return sx;
            4'd11: return a - b;
            4'd12: return a - b;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE. The task checks EXEC and the writeback
    // record, holds off wb_ready for 'stall' cycles and then releases it.
    // With 'abort' set, reset is pulsed while the record is in WB instead.
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [15:0] a,
                           input logic [15:0] b, input logic [5:0] imm, input int stall,
                           input bit abort);
        logic [15:0] exp_data;
        logic        exp_we, exp_err, exp_br;
        exp_data = ref_data(op, a, b, imm);
        exp_err  = (op >= 4'd13);
        exp_we   = (op <= 4'd10);
        exp_br   = (op == 4'd11) && (exp_data == 16'h0);
        if (!exp_err) model_z = (exp_data == 16'h0);

        check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_rd     = rd;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_imm    = imm;
        bus.wb_ready   = (stall == 0 && !abort);
        @(negedge clk);
        // Keep offering junk so that any accept outside IDLE is caught.
        bus.cmd_opcode = 4'($urandom);
        bus.cmd_rd     = 3'($urandom);
        bus.cmd_a      = 16'($urandom);
        bus.cmd_b      = 16'($urandom);
        bus.cmd_imm    = 6'($urandom);
        check("exec_ready", 32'(bus.cmd_ready), 32'd0);
        check("exec_wb_valid", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        check("wb_valid", 32'(bus.wb_valid), 32'd1);
        check("wb_data", 32'(bus.wb_data), 32'(exp_data));
        check("wb_rd", 32'(bus.wb_rd), 32'(rd));
        check("wb_we", 32'(bus.wb_we), 32'(exp_we));
        check("wb_err", 32'(bus.wb_err), 32'(exp_err));
        check("branch_taken", 32'(bus.branch_taken), 32'(exp_br));
        check("flag_z", 32'(bus.flag_z), 32'(model_z));
        check("wb_ready_out", 32'(bus.cmd_ready), 32'd0);
        $display("cmd op=%0d rd=%0d a=%h b=%h imm=%h -> data=%h we=%0d err=%0d br=%0d z=%0d stall=%0d",
                 op, rd, a, b, imm, bus.wb_data, bus.wb_we, bus.wb_err, bus.branch_taken,
                 bus.flag_z, stall);
        if (abort) begin
            #2 rst_n = 1'b0;
            #1;
            model_z = 1'b0;
            check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
            check("rst_flag_z", 32'(bus.flag_z), 32'd0);
            check("rst_ready", 32'(bus.cmd_ready), 32'd1);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.wb_ready  = 1'b1;
            rst_n         = 1'b1;
            @(negedge clk);
            check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
            check("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        end else begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_wb_valid", 32'(bus.wb_valid), 32'd1);
                check("stall_wb_data", 32'(bus.wb_data), 32'(exp_data));
                check("stall_wb_rd", 32'(bus.wb_rd), 32'(rd));
                check("stall_ready", 32'(bus.cmd_ready), 32'd0);
            end
            bus.wb_ready = 1'b1;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            check("done_wb_valid", 32'(bus.wb_valid), 32'd0);
            check("done_ready", 32'(bus.cmd_ready), 32'd1);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        rst_n          = 1'b0;
        model_z        = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_rd     = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.cmd_imm    = '0;
        bus.wb_ready   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("reset_alu_op", 32'(bus.alu_op), 32'd0);
        check("reset_alu_a", 32'(bus.alu_a), 32'd0);
        check("reset_flag_z", 32'(bus.flag_z), 32'd0);
        check("reset_wb_data", 32'(bus.wb_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_cmd(4'd0, 3'd1, 16'd54, 16'd5, 6'd0, 0, 1'b0);
        run_cmd(4'd1, 3'd2, 16'd5, 16'd5, 6'd0, 0, 1'b0);
        run_cmd(4'd5, 3'd3, 16'd0, 16'd3, 6'd0, 0, 1'b0);
        run_cmd(4'd8, 3'd4, 16'd10, 16'd0, 6'b111110, 0, 1'b0);
        run_cmd(4'd10, 3'd5, 16'd1234, 16'd99, 6'b100000, 0, 1'b0);
        run_cmd(4'd11, 3'd6, 16'd7, 16'd7, 6'd0, 0, 1'b0);
        run_cmd(4'd11, 3'd6, 16'd7, 16'd8, 6'd0, 0, 1'b0);
        run_cmd(4'd3, 3'd7, 16'h00F1, 16'd4, 6'd0, 4, 1'b0);
        run_cmd(4'd1, 3'd2, 16'd9, 16'd9, 6'd0, 0, 1'b0);
        run_cmd(4'd13, 3'd1, 16'd9, 16'd3, 6'd5, 0, 1'b0);
        run_cmd(4'd0, 3'd3, 16'd1, 16'd2, 6'd0, 2, 1'b1);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            if (op == 4'd2 || op == 4'd3 || op == 4'd7) b = 16'($urandom_range(0, 17));
            else if ($urandom_range(0, 3) == 0)         b = a;
            else                                        b = 16'($urandom);
            run_cmd(op, 3'($urandom), a, b, 6'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
